// File: rtl/timer_bank_if.sv
// timer_bank_if: shared bus slot of the timer bank
// Ports: chip_select/write strobe a write of data_in to address {channel, offset};
//        data_out is the combinational read of address; irq/irq_any are the interrupt lines.
interface timer_bank_if #(
    parameter int CHANNELS = 4
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    logic                chip_select;
    logic                write;
    logic [CH_W+2:0]     address;
    logic [31:0]         data_in;
    logic [31:0]         data_out;
    logic [CHANNELS-1:0] irq;
    logic                irq_any;
    modport master (output chip_select, write, address, data_in, input data_out, irq, irq_any);
    modport slave (input chip_select, write, address, data_in, output data_out, irq, irq_any);
endinterface

// File: rtl/timer_bank.sv
// timer_bank: multi-channel prescaled up-counter timers with compare match interrupts
// Ports: clk, rst (sync, active-high); bus (timer_bank_if.slave) carries the
//        chip_select/write register bus, combinational data_out, irq[CHANNELS] and irq_any.
module timer_bank #(
    parameter int CHANNELS      = 4,
    parameter int WIDTH         = 32,
    parameter int PRESCALE_BITS = 16
) (
    input logic        clk,
    input logic        rst,
    timer_bank_if.slave bus
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    logic [CH_W-1:0] idx;
    logic [2:0]      off;
    logic [31:0]     rd [CHANNELS];
    assign idx = bus.address[CH_W+2:3];
    assign off = bus.address[2:0];
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic                     en_q, en_d, per_q, per_d, ie_q, ie_d, flag_q, flag_d;
        logic [PRESCALE_BITS-1:0] ps_q, ps_d, pre_q, pre_d;
        logic [WIDTH-1:0]         cmp_q, cmp_d, cnt_q, cnt_d;
        logic [7:0]               wr;
        logic                     tick, match, restart;
        assign wr      = (bus.chip_select & bus.write & (idx == CH_W'(c))) ? 8'd1 << off : 8'd0;
        assign tick    = en_q & (pre_q == ps_q);
        assign match   = tick & (cnt_q == cmp_q);
        assign restart = wr[5] & bus.data_in[0];
        // Later terms in each chain lose to earlier ones: restart > bus write > tick.
        always_comb begin
            en_d   = (wr[5] & bus.data_in[1]) ? 1'b1 : wr[0] ? bus.data_in[0] : (match & ~per_q) ? 1'b0 : en_q;
            per_d  = wr[0] ? bus.data_in[1] : per_q;
            ie_d   = wr[0] ? bus.data_in[2] : ie_q;
            ps_d   = wr[1] ? bus.data_in[PRESCALE_BITS-1:0] : ps_q;
            cmp_d  = wr[2] ? bus.data_in[WIDTH-1:0] : cmp_q;
            pre_d  = (wr[1] | restart | tick) ? '0 : en_q ? pre_q + 1'b1 : pre_q;
            cnt_d  = restart ? '0 : wr[3] ? bus.data_in[WIDTH-1:0] : match ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
            // A match in the same cycle wins over a write-1-to-clear.
            flag_d = ~restart & (match | (flag_q & ~(wr[4] & bus.data_in[0])));
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                en_q   <= 1'b0;
                per_q  <= 1'b0;
                ie_q   <= 1'b0;
                flag_q <= 1'b0;
                ps_q   <= PRESCALE_BITS'(63);
                pre_q  <= '0;
                cmp_q  <= '0;
                cnt_q  <= '0;
            end else begin
                en_q   <= en_d;
                per_q  <= per_d;
                ie_q   <= ie_d;
                flag_q <= flag_d;
                ps_q   <= ps_d;
                pre_q  <= pre_d;
                cmp_q  <= cmp_d;
                cnt_q  <= cnt_d;
            end
        end
        assign rd[c] = (off == 3'd0) ? {29'd0, ie_q, per_q, en_q} :
                       (off == 3'd1) ? 32'(ps_q) :
                       (off == 3'd2) ? 32'(cmp_q) :
                       (off == 3'd3) ? 32'(cnt_q) :
                       (off == 3'd4) ? {31'd0, flag_q} : 32'd0;
        assign bus.irq[c] = flag_q & ie_q;
    end
    assign bus.data_out = (32'(idx) < CHANNELS) ? rd[idx] : 32'd0;
    assign bus.irq_any  = |bus.irq;
endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed and random stimulus against a behavioural model of the timer bank
module tb_timer_bank;
    localparam int CH = 4, W = 32, PB = 16;
    localparam longint CMOD = 64'd1 << W;
    localparam longint PMOD = 64'd1 << PB;
    logic clk = 0, rst = 1;
    timer_bank_if #(.CHANNELS(CH)) bus();
    timer_bank #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_BITS(PB)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #100 clk = ~clk;
    int n_cmp = 0, n_bad = 0;
    bit     m_en [CH], m_per [CH], m_ie [CH], m_flag [CH];
    longint m_ps [CH], m_pre [CH], m_cmp [CH], m_cnt [CH];
    bit     d_cs, d_w;
    int     d_c, d_o;
    longint d_d;
    logic [31:0] v;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint m_read(int c, int o);
        case (o)
            0: return m_en[c] + 2 * m_per[c] + 4 * m_ie[c];
            1: return m_ps[c];
            2: return m_cmp[c];
            3: return m_cnt[c];
            4: return longint'(m_flag[c]);
            default: return 0;
        endcase
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_en[c] = 0; m_per[c] = 0; m_ie[c] = 0; m_flag[c] = 0;
            m_ps[c] = 63; m_pre[c] = 0; m_cmp[c] = 0; m_cnt[c] = 0;
        end
    endfunction

    // One clock of the timer rules: tick behaviour first, then the bus write overrides it.
    function automatic void model_step();
        for (int c = 0; c < CH; c++) begin
            bit tk, mt;
            tk = m_en[c] && m_pre[c] == m_ps[c];
            mt = tk && m_cnt[c] == m_cmp[c];
            if (m_en[c]) m_pre[c] = tk ? 0 : m_pre[c] + 1;
            if (mt) begin
                m_flag[c] = 1;
                m_cnt[c] = 0;
                if (!m_per[c]) m_en[c] = 0;
            end else if (tk) m_cnt[c] = (m_cnt[c] + 1) % CMOD;
            if (d_cs && d_w && d_c == c) begin
                case (d_o)
                    0: begin m_en[c] = d_d[0]; m_per[c] = d_d[1]; m_ie[c] = d_d[2]; end
                    1: begin m_ps[c] = d_d % PMOD; m_pre[c] = 0; end
                    2: m_cmp[c] = d_d % CMOD;
                    3: m_cnt[c] = d_d % CMOD;
                    4: if (d_d[0] && !mt) m_flag[c] = 0;
                    5: begin
                        if (d_d[0]) begin m_cnt[c] = 0; m_pre[c] = 0; m_flag[c] = 0; end
                        if (d_d[1]) m_en[c] = 1;
                    end
                    default: ;
                endcase
            end
        end
    endfunction

    task automatic check_all();
        logic [CH-1:0] ei;
        for (int c = 0; c < CH; c++) begin
            ei[c] = m_flag[c] & m_ie[c];
            for (int o = 0; o < 8; o++) begin
                bus.address = 5'(c * 8 + o);
                #1;
                chk($sformatf("rd ch%0d off%0d", c, o), bus.data_out, 32'(m_read(c, o)));
            end
        end
        chk("irq", 32'(bus.irq), 32'(ei));
        chk("irq_any", 32'(bus.irq_any), 32'(|ei));
    endtask

    task automatic drive(bit cs, bit w, int c, int o, longint d);
        d_cs = cs; d_w = w; d_c = c; d_o = o; d_d = d;
        bus.chip_select = cs;
        bus.write = w;
        bus.address = 5'(c * 8 + o);
        bus.data_in = 32'(d);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
        drive(0, 0, 0, 0, 0);
        check_all();
    endtask

    task automatic wr(int c, int o, longint d);
        drive(1, 1, c, o, d);
        step();
    endtask

    task automatic rd(int c, int o, output logic [31:0] val);
        bus.address = 5'(c * 8 + o);
        #1;
        val = bus.data_out;
    endtask

    task automatic wait_tick(int c, bit need_match, string tag);
        int k;
        for (k = 0; k < 50; k++) begin
            if (m_en[c] && m_pre[c] == m_ps[c] && (!need_match || m_cnt[c] == m_cmp[c])) break;
            step();
        end
        n_cmp++;
        assert (k < 50) else begin
            n_bad++;
            $error("FAIL %s: observed timeout expected event within 50 cycles", tag);
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        rst = 1;
        step();
        step();
        rst = 0;
        rd(0, 0, v); chk("rst ctrl", v, 0);
        rd(0, 1, v); chk("rst prescale", v, 63);
        rd(0, 2, v); chk("rst compare", v, 0);
        rd(0, 3, v); chk("rst count", v, 0);
        rd(0, 4, v); chk("rst status", v, 0);
        chk("rst irq", 32'(bus.irq), 0);
        // ch0 periodic, divide by 1, compare 5
        wr(0, 1, 0);
        wr(0, 2, 5);
        wr(0, 0, 7);
        for (int k = 1; k <= 6; k++) begin
            step();
            rd(0, 3, v);
            chk($sformatf("ch0 count step%0d", k), v, 32'(k % 6));
        end
        chk("ch0 irq after match", 32'(bus.irq[0]), 1);
        wr(0, 4, 1);
        chk("ch0 irq after w1c", 32'(bus.irq[0]), 0);
        repeat (4) step();
        chk("ch0 irq before rematch", 32'(bus.irq[0]), 0);
        step();
        chk("ch0 irq rematch", 32'(bus.irq[0]), 1);
        // ch1 one-shot, divide by 4, compare 2
        wr(1, 1, 3);
        wr(1, 2, 2);
        wr(1, 0, 1);
        repeat (4) step();
        rd(1, 3, v); chk("ch1 count first tick", v, 1);
        repeat (7) step();
        rd(1, 3, v); chk("ch1 count before match", v, 2);
        step();
        rd(1, 3, v); chk("ch1 count after match", v, 0);
        rd(1, 0, v); chk("ch1 ctrl disabled", v, 0);
        rd(1, 4, v); chk("ch1 flag", v, 1);
        repeat (20) step();
        rd(1, 3, v); chk("ch1 count held", v, 0);
        // ch2 wrap from all-ones does not flag
        wr(2, 3, 64'hFFFF_FFFF);
        wr(2, 2, 10);
        wr(2, 1, 0);
        wr(2, 0, 1);
        step();
        rd(2, 3, v); chk("ch2 wrap count", v, 0);
        rd(2, 4, v); chk("ch2 wrap no flag", v, 0);
        repeat (10) step();
        rd(2, 3, v); chk("ch2 count at compare", v, 10);
        step();
        rd(2, 4, v); chk("ch2 flag on match", v, 1);
        rd(2, 3, v); chk("ch2 count after match", v, 0);
        // ch3 collisions, divide by 2, periodic
        wr(3, 1, 1);
        wr(3, 2, 32'h300);
        wr(3, 0, 3);
        wait_tick(3, 0, "ch3 wait tick");
        wr(3, 3, 32'h100);
        rd(3, 3, v); chk("ch3 count write beats tick", v, 32'h100);
        wr(3, 2, 32'h103);
        wait_tick(3, 1, "ch3 wait match");
        wr(3, 4, 1);
        rd(3, 4, v); chk("ch3 match beats w1c", v, 1);
        repeat (3) step();
        wr(3, 5, 1);
        rd(3, 3, v); chk("ch3 restart count", v, 0);
        rd(3, 4, v); chk("ch3 restart flag", v, 0);
        // isolation: disturb ch1 and unused offsets while ch0/ch3 run
        for (int k = 0; k < 40; k++) begin
            if (k % 2 == 0) drive(1, 1, 1, $urandom_range(0, 5), $urandom_range(0, 7));
            else drive(1, 1, (k % 4 == 1) ? 0 : 3, $urandom_range(6, 7), $urandom);
            step();
        end
        rst = 1;
        step();
        rst = 0;
        for (int c = 0; c < CH; c++) begin
            rd(c, 0, v); chk($sformatf("midrst ctrl ch%0d", c), v, 0);
            rd(c, 1, v); chk($sformatf("midrst prescale ch%0d", c), v, 63);
            rd(c, 3, v); chk($sformatf("midrst count ch%0d", c), v, 0);
        end
        // random traffic
        for (int k = 0; k < 500; k++) begin
            int o;
            longint d;
            o = $urandom_range(0, 7);
            case (o)
                0: d = $urandom_range(0, 7);
                1: d = $urandom_range(0, 3);
                2: d = $urandom_range(0, 10);
                3: d = ($urandom_range(0, 7) == 0) ? longint'($urandom) : longint'($urandom_range(0, 12));
                default: d = $urandom_range(0, 3);
            endcase
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, $urandom_range(0, CH - 1), o, d);
            rst = ($urandom_range(0, 149) == 0);
            step();
            rst = 0;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
Multi-channel, parametrised memory-mapped timer peripheral; the successor to the single-counter timer device on the CPU peripheral bus. Each channel has its own prescaler, up-counter, compare register, periodic/one-shot mode and maskable match interrupt. All channels share one chip-select/write bus slot. The interrupt outputs feed the interrupt controller.

Parameters:
CHANNELS, 4, number of independent timer channels (1..16)
WIDTH, 32, counter/compare width in bits (8..32); register reads are zero-extended to 32
PRESCALE_BITS, 16, prescaler reload width (1..32)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
chip_select  input  1  block selected for this bus cycle
write  input  1  write strobe; acts only when chip_select=1
address  input  CH_W+3  {channel index, register offset[2:0]}; CH_W = max(1, clog2(CHANNELS))
data_in  input  32  write data
data_out  output  32  read data, combinational from address
irq  output  CHANNELS  per-channel interrupt, level = match_flag & irq_en
irq_any  output  1  OR of irq

Behaviour:
- Reset: synchronous, active-high, on clk. Per channel: enable=0, periodic=0, irq_en=0, prescale=63, compare=0, count=0, prescaler counter pre=0, match_flag=0. After reset: irq=0, irq_any=0, data_out = value of the addressed register.
- Register offsets per channel:
  - 0 CTRL: bit0 enable, bit1 periodic, bit2 irq_en.
  - 1 PRESCALE: [PRESCALE_BITS-1:0].
  - 2 COMPARE: [WIDTH-1:0].
  - 3 COUNT: [WIDTH-1:0].
  - 4 STATUS: bit0 match_flag, write-1-to-clear.
  - 5 CMD: write-only. bit0 restart sets count=0, pre=0, flag=0. bit1 start sets enable=1. Both set: restart and enable in the same cycle.
  - 6, 7 and channel index >= CHANNELS: read 0, writes ignored.
- Reads: data_out combinational. Unused upper bits read 0. No read side effects.
- Writes take effect at the next clk edge.
- Prescaler, every cycle with enable=1:
  - pre==prescale: pre<=0 and tick=1.
  - otherwise: pre<=pre+1.
  - Count divides clk by prescale+1. prescale=0 ticks every cycle; no divide-by-zero case.
  - enable=0: pre and count hold (pause, not reset).
  - Writing PRESCALE also clears pre.
  - A new prescale value below the current pre takes effect immediately, because pre is cleared.
- Counter, on tick:
  - count==compare: match_flag<=1.
    - Periodic: count<=0.
    - One-shot: count<=0 and enable<=0.
  - Otherwise: count<=count+1, wrapping mod 2^WIDTH. The wrap itself raises no flag.
  - compare=0 in periodic mode: match on every tick; count stays 0.
- Timing from enable: first tick after prescale+1 enabled cycles. COUNT reads 1 on the cycle after that tick, unless a match occurred.
- Same-cycle priority, highest first: rst > CMD restart > bus write of COUNT > tick update.
  - A COUNT write in a tick cycle loads data_in; the tick is lost, but the match comparison still uses the old count.
  - Match set beats a STATUS W1C in the same cycle: flag stays 1.
  - A CTRL write in a tick cycle: the tick completes using the old mode. The one-shot enable clear is overridden by a CTRL write of enable=1.
- irq: registered-state derived, no extra latency. It rises the cycle after the match edge and stays high until the flag is cleared or irq_en=0.
- Channels are fully independent. Writes to one channel never disturb another.

Test Plan:
- Reset, then read every offset of channel 0 -> CTRL=0, PRESCALE=63, COMPARE=0, COUNT=0, STATUS=0; irq=0.
- Ch0: PRESCALE=0, COMPARE=5, CTRL=0b111 (periodic, irq_en, enable) -> COUNT steps 1,2,3,4,5,0 on consecutive cycles; irq[0] rises the cycle after COUNT=5→0; W1C STATUS clears irq; the next match 6 cycles later re-raises it.
- Ch1: PRESCALE=3, COMPARE=2, one-shot, enable -> COUNT increments every 4 cycles: 1, 2, then 0; enable reads 0 afterwards; COUNT holds 0 for 20 more cycles.
- Ch2: COUNT=0xFFFFFFFF, COMPARE=10, PRESCALE=0, enable -> COUNT wraps to 0 with no flag; flag sets when COUNT 10→0.
- Collisions: COUNT write coincident with tick loads 0x100; STATUS W1C coincident with match leaves flag=1; CMD restart during run yields COUNT=0, pre=0, flag=0 next cycle.
- Isolation/decoding: run ch0 and ch3 with different prescalers; writes to ch1 and offsets 6/7 do not perturb either; irq_any equals OR of irq every cycle; rst asserted mid-run restores all reset values next cycle.
